// File: rtl/exc_pkg.sv
// exc_pkg: shared constants and types for the precise-exception sequencer.
//   - Exception type codes as delivered by the MEM-stage exception decoder.
//   - CP0 Cause.ExcCode values.
//   - Default fetch vector for non-eret exceptions.
//   - Sequencer state enum and a trigger-recognition helper.
package exc_pkg;

    localparam logic [31:0] TYPE_INT  = 32'h0000_0001;
    localparam logic [31:0] TYPE_ADEL = 32'h0000_0004;
    localparam logic [31:0] TYPE_ADES = 32'h0000_0005;
    localparam logic [31:0] TYPE_SYS  = 32'h0000_0008;
    localparam logic [31:0] TYPE_BP   = 32'h0000_0009;
    localparam logic [31:0] TYPE_RI   = 32'h0000_000A;
    localparam logic [31:0] TYPE_OV   = 32'h0000_000C;
    localparam logic [31:0] TYPE_ERET = 32'h0000_000E;
    localparam logic [31:0] TYPE_NONE = 32'hFFFF_FFFF;

    localparam logic [4:0] EXC_CODE_INT  = 5'd0;
    localparam logic [4:0] EXC_CODE_ADEL = 5'd4;
    localparam logic [4:0] EXC_CODE_ADES = 5'd5;
    localparam logic [4:0] EXC_CODE_SYS  = 5'd8;
    localparam logic [4:0] EXC_CODE_BP   = 5'd9;
    localparam logic [4:0] EXC_CODE_RI   = 5'd10;
    localparam logic [4:0] EXC_CODE_OV   = 5'd12;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StCommit
    } exc_state_e;

    // Only the eight listed codes start a sequence; anything else (incl. NONE) is ignored.
    function automatic logic is_trigger(input logic [31:0] exc_type);
        logic hit;
        hit = 1'b0;
        case (exc_type)
            TYPE_INT, TYPE_ADEL, TYPE_ADES, TYPE_SYS,
            TYPE_BP, TYPE_RI, TYPE_OV, TYPE_ERET: hit = 1'b1;
            default:                              hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/exc_code_map.sv
// exc_code_map: combinational decode of an exception type code.
// Ports:
//   type_i         exception type code
//   valid_o        type is one of the recognised codes
//   is_eret_o      type is eret
//   exc_code_o     Cause.ExcCode for exception types (0 for eret / unknown)
//   bad_vaddr_we_o type reports a faulting address (AdEL/AdES)
module exc_code_map
    import exc_pkg::*;
(
    input  logic [31:0] type_i,
    output logic        valid_o,
    output logic        is_eret_o,
    output logic [4:0]  exc_code_o,
    output logic        bad_vaddr_we_o
);

    always_comb begin
        valid_o        = 1'b1;
        is_eret_o      = 1'b0;
        exc_code_o     = 5'd0;
        bad_vaddr_we_o = 1'b0;
        case (type_i)
            TYPE_INT:  exc_code_o = EXC_CODE_INT;
            TYPE_ADEL: begin
                exc_code_o     = EXC_CODE_ADEL;
                bad_vaddr_we_o = 1'b1;
            end
            TYPE_ADES: begin
                exc_code_o     = EXC_CODE_ADES;
                bad_vaddr_we_o = 1'b1;
            end
            TYPE_SYS:  exc_code_o = EXC_CODE_SYS;
            TYPE_BP:   exc_code_o = EXC_CODE_BP;
            TYPE_RI:   exc_code_o = EXC_CODE_RI;
            TYPE_OV:   exc_code_o = EXC_CODE_OV;
            TYPE_ERET: is_eret_o  = 1'b1;
            default:   valid_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: sequences precise exceptions and eret for the MEM stage.
// Accepts a trigger in IDLE, waits in DRAIN while a bus transaction is outstanding,
// then issues a single COMMIT cycle that writes CP0, flushes and redirects fetch.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   exceptionTypeM       prioritised exception type in MEM
//   pcM, badAddrM        MEM-stage PC and faulting address
//   isInDelaySlotM       MEM instruction sits in a branch delay slot
//   epcIn                current CP0 EPC (eret target)
//   memBusy              bus transaction outstanding
//   stallReq, flushAll   hazard-unit controls
//   newPcValid, newPc    fetch redirect
//   cp0*                 CP0 write controls and data
//   busy                 sequencer not idle
// Configuration macro: EXC_BD_EN -- when defined, a delay-slot instruction reports
// EPC = pc - 4 and Cause.BD = 1; when undefined the delay-slot flag is ignored.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] exceptionTypeM,
    input  logic [31:0] pcM,
    input  logic [31:0] badAddrM,
    input  logic        isInDelaySlotM,
    input  logic [31:0] epcIn,
    input  logic        memBusy,
    output logic        stallReq,
    output logic        flushAll,
    output logic        newPcValid,
    output logic [31:0] newPc,
    output logic        cp0ExcWe,
    output logic [4:0]  cp0ExcCode,
    output logic [31:0] cp0Epc,
    output logic        cp0Bd,
    output logic        cp0BadVAddrWe,
    output logic [31:0] cp0BadVAddr,
    output logic        cp0ExlClr,
    output logic        busy
);

    exc_state_e  state_q, state_d;
    logic [31:0] type_q, type_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] bad_q, bad_d;
    logic [31:0] epc_q, epc_d;
    logic        trigger;
    logic        capture;

    logic        map_valid;
    logic        map_is_eret;
    logic [4:0]  map_exc_code;
    logic        map_bad_vaddr_we;

    logic [31:0] epc_report;
    logic        bd_report;

`ifdef EXC_BD_EN
    logic bd_q, bd_d;
    assign bd_d       = capture ? isInDelaySlotM : bd_q;
    assign bd_report  = bd_q;
    assign epc_report = bd_q ? (pc_q - 32'd4) : pc_q;
`else
    logic unused_in_delay_slot;
    assign unused_in_delay_slot = isInDelaySlotM;
    assign bd_report  = 1'b0;
    assign epc_report = pc_q;
`endif

    assign trigger = is_trigger(exceptionTypeM);
    assign capture = (state_q == StIdle) && trigger;

    assign type_d = capture ? exceptionTypeM : type_q;
    assign pc_d   = capture ? pcM            : pc_q;
    assign bad_d  = capture ? badAddrM       : bad_q;
    assign epc_d  = capture ? epcIn          : epc_q;

    exc_code_map u_exc_code_map (
        .type_i         (type_q),
        .valid_o        (map_valid),
        .is_eret_o      (map_is_eret),
        .exc_code_o     (map_exc_code),
        .bad_vaddr_we_o (map_bad_vaddr_we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            type_q  <= 32'd0;
            pc_q    <= 32'd0;
            bad_q   <= 32'd0;
            epc_q   <= 32'd0;
`ifdef EXC_BD_EN
            bd_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            pc_q    <= pc_d;
            bad_q   <= bad_d;
            epc_q   <= epc_d;
`ifdef EXC_BD_EN
            bd_q    <= bd_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        stallReq      = 1'b0;
        flushAll      = 1'b0;
        newPcValid    = 1'b0;
        newPc         = 32'd0;
        cp0ExcWe      = 1'b0;
        cp0ExcCode    = 5'd0;
        cp0Epc        = 32'd0;
        cp0Bd         = 1'b0;
        cp0BadVAddrWe = 1'b0;
        cp0BadVAddr   = 32'd0;
        cp0ExlClr     = 1'b0;
        busy          = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    stallReq = 1'b1;
                    state_d  = memBusy ? StDrain : StCommit;
                end
            end
            StDrain: begin
                stallReq = 1'b1;
                if (!memBusy) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                state_d    = StIdle;
                flushAll   = 1'b1;
                newPcValid = 1'b1;
                if (map_is_eret) begin
                    cp0ExlClr = 1'b1;
                    newPc     = epc_q;
                end else if (map_valid) begin
                    cp0ExcWe      = 1'b1;
                    cp0ExcCode    = map_exc_code;
                    cp0Epc        = epc_report;
                    cp0Bd         = bd_report;
                    newPc         = EXC_VECTOR;
                    cp0BadVAddrWe = map_bad_vaddr_we;
                    cp0BadVAddr   = map_bad_vaddr_we ? bad_q : 32'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: directed and randomised checks of exception_ctrl against a
// table-driven reference of the commit contents and event timeline.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] exceptionTypeM;
    logic [31:0] pcM;
    logic [31:0] badAddrM;
    logic        isInDelaySlotM;
    logic [31:0] epcIn;
    logic        memBusy;
    logic        stallReq;
    logic        flushAll;
    logic        newPcValid;
    logic [31:0] newPc;
    logic        cp0ExcWe;
    logic [4:0]  cp0ExcCode;
    logic [31:0] cp0Epc;
    logic        cp0Bd;
    logic        cp0BadVAddrWe;
    logic [31:0] cp0BadVAddr;
    logic        cp0ExlClr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    exception_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .exceptionTypeM (exceptionTypeM),
        .pcM            (pcM),
        .badAddrM       (badAddrM),
        .isInDelaySlotM (isInDelaySlotM),
        .epcIn          (epcIn),
        .memBusy        (memBusy),
        .stallReq       (stallReq),
        .flushAll       (flushAll),
        .newPcValid     (newPcValid),
        .newPc          (newPc),
        .cp0ExcWe       (cp0ExcWe),
        .cp0ExcCode     (cp0ExcCode),
        .cp0Epc         (cp0Epc),
        .cp0Bd          (cp0Bd),
        .cp0BadVAddrWe  (cp0BadVAddrWe),
        .cp0BadVAddr    (cp0BadVAddr),
        .cp0ExlClr      (cp0ExlClr),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Reference tables: exception types and their Cause.ExcCode; eret is 0xE.
    logic [31:0] exc_types [7] = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC};
    logic [4:0]  exc_codes [7] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
    logic [31:0] trig_list [8] = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC, 32'hE};

    typedef struct packed {
        logic        exc_we;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic        bv_we;
        logic [31:0] bv;
        logic        exl_clr;
        logic [31:0] new_pc;
    } commit_t;

    function automatic commit_t ref_commit(input logic [31:0] t, input logic [31:0] pc,
                                           input logic [31:0] bad, input logic ds,
                                           input logic [31:0] epc);
        commit_t e;
        e = '0;
        if (t == 32'hE) begin
            e.exl_clr = 1'b1;
            e.new_pc  = epc;
        end else begin
            e.exc_we = 1'b1;
            e.new_pc = 32'hBFC0_0380;
            for (int k = 0; k < 7; k++) begin
                if (exc_types[k] == t) e.code = exc_codes[k];
            end
            e.bv_we = (t == 32'h4) || (t == 32'h5);
            e.bv    = bad;
`ifdef EXC_BD_EN
            e.epc = ds ? pc - 32'd4 : pc;
            e.bd  = ds;
`else
            e.epc = pc;
            e.bd  = 1'b0;
            if (ds) e.bd = 1'b0;
`endif
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Non-commit cycle: every CP0/redirect output must be 0.
    task automatic chk_quiet(input string tag, input logic exp_stall, input logic exp_busy);
        chk({tag, ".stallReq"}, 32'(stallReq), 32'(exp_stall));
        chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
        chk({tag, ".flushAll"}, 32'(flushAll), 32'd0);
        chk({tag, ".newPcValid"}, 32'(newPcValid), 32'd0);
        chk({tag, ".newPc"}, newPc, 32'd0);
        chk({tag, ".cp0ExcWe"}, 32'(cp0ExcWe), 32'd0);
        chk({tag, ".cp0ExcCode"}, 32'(cp0ExcCode), 32'd0);
        chk({tag, ".cp0Epc"}, cp0Epc, 32'd0);
        chk({tag, ".cp0Bd"}, 32'(cp0Bd), 32'd0);
        chk({tag, ".cp0BadVAddrWe"}, 32'(cp0BadVAddrWe), 32'd0);
        chk({tag, ".cp0BadVAddr"}, cp0BadVAddr, 32'd0);
        chk({tag, ".cp0ExlClr"}, 32'(cp0ExlClr), 32'd0);
    endtask

    task automatic chk_commit(input string tag, input commit_t e);
        chk({tag, ".stallReq"}, 32'(stallReq), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".flushAll"}, 32'(flushAll), 32'd1);
        chk({tag, ".newPcValid"}, 32'(newPcValid), 32'd1);
        chk({tag, ".newPc"}, newPc, e.new_pc);
        chk({tag, ".cp0ExcWe"}, 32'(cp0ExcWe), 32'(e.exc_we));
        chk({tag, ".cp0ExlClr"}, 32'(cp0ExlClr), 32'(e.exl_clr));
        chk({tag, ".cp0BadVAddrWe"}, 32'(cp0BadVAddrWe), 32'(e.bv_we));
        if (e.exc_we) begin
            chk({tag, ".cp0ExcCode"}, 32'(cp0ExcCode), 32'(e.code));
            chk({tag, ".cp0Epc"}, cp0Epc, e.epc);
            chk({tag, ".cp0Bd"}, 32'(cp0Bd), 32'(e.bd));
        end
        if (e.bv_we) chk({tag, ".cp0BadVAddr"}, cp0BadVAddr, e.bv);
    endtask

    // Random inputs carrying a valid trigger, which must be ignored outside IDLE.
    task automatic drive_junk();
        exceptionTypeM = trig_list[$urandom_range(7)];
        pcM            = $urandom;
        badAddrM       = $urandom;
        isInDelaySlotM = 1'($urandom_range(1));
        epcIn          = $urandom;
    endtask

    // Called just after a clock edge with the DUT idle; memBusy is high for the
    // first nbusy cycles of the event, so COMMIT lands nbusy + 1 cycles later.
    task automatic run_event(input string tag, input logic [31:0] t, input logic [31:0] pc,
                             input logic [31:0] bad, input logic ds,
                             input logic [31:0] epc, input int nbusy);
        commit_t e;
        e = ref_commit(t, pc, bad, ds, epc);
        exceptionTypeM = t;
        pcM            = pc;
        badAddrM       = bad;
        isInDelaySlotM = ds;
        epcIn          = epc;
        memBusy        = (nbusy > 0);
        #3;
        chk_quiet({tag, ".trig"}, 1'b1, 1'b0);
        for (int i = 1; i <= nbusy; i++) begin
            tick();
            drive_junk();
            memBusy = (i < nbusy);
            #3;
            chk_quiet({tag, ".drain"}, 1'b1, 1'b1);
        end
        tick();
        drive_junk();
        memBusy = 1'($urandom_range(1));
        #3;
        chk_commit({tag, ".commit"}, e);
        tick();
    endtask

    task automatic idle_cycle(input string tag);
        exceptionTypeM = 32'hFFFF_FFFF;
        memBusy        = 1'($urandom_range(1));
        #3;
        chk_quiet(tag, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        logic [31:0] nt;
        rst            = 1'b1;
        exceptionTypeM = 32'hFFFF_FFFF;
        pcM            = 32'd0;
        badAddrM       = 32'd0;
        isInDelaySlotM = 1'b0;
        epcIn          = 32'd0;
        memBusy        = 1'b0;
        tick();
        tick();
        #3;
        chk_quiet("reset", 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        // Directed cases.
        run_event("sys", 32'h8, 32'h8000_0010, 32'h0, 1'b0, 32'h0, 0);
        idle_cycle("idle0");
        run_event("adel", 32'h4, 32'h8000_0040, 32'h1234_5679, 1'b0, 32'h0, 3);
        run_event("eret", 32'hE, 32'h8000_0080, 32'h0, 1'b0, 32'hBFC0_0100, 0);
        run_event("ov_ds", 32'hC, 32'h8000_0024, 32'h0, 1'b1, 32'h0, 1);
        run_event("ov_nods", 32'hC, 32'h8000_0024, 32'h0, 1'b0, 32'h0, 0);
        run_event("ades", 32'h5, 32'h8000_0100, 32'hDEAD_BEE1, 1'b0, 32'h0, 2);

        // Non-trigger codes: no stall, stays idle.
        exceptionTypeM = 32'h3;
        #3;
        chk_quiet("undef3", 1'b0, 1'b0);
        tick();
        exceptionTypeM = 32'hFFFF_FFFF;
        #3;
        chk_quiet("none", 1'b0, 1'b0);
        tick();
        for (int n = 0; n < 6; n++) begin
            nt = $urandom;
            if (nt[3:0] == 4'h0) nt[4] = 1'b1;
            if (nt < 32'h10) nt = nt + 32'h10;
            exceptionTypeM = nt;
            memBusy        = 1'($urandom_range(1));
            #3;
            chk_quiet("undef_rand", 1'b0, 1'b0);
            tick();
        end
        idle_cycle("idle_after_undef");

        // Reset in the second DRAIN cycle: event must never commit.
        exceptionTypeM = 32'h9;
        pcM            = 32'h8000_0200;
        memBusy        = 1'b1;
        tick();
        drive_junk();
        memBusy = 1'b1;
        #3;
        chk_quiet("rstdrain.d1", 1'b1, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        exceptionTypeM = 32'hFFFF_FFFF;
        memBusy        = 1'b0;
        #3;
        chk_quiet("rstdrain.after", 1'b0, 1'b0);
        tick();
        idle_cycle("rstdrain.after2");

        // Reset during COMMIT: next cycle idle with nothing asserted.
        exceptionTypeM = 32'hA;
        memBusy        = 1'b0;
        tick();
        rst = 1'b1;
        exceptionTypeM = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0;
        #3;
        chk_quiet("rstcommit.after", 1'b0, 1'b0);
        tick();

        // Randomised back-to-back events with occasional idle gaps.
        for (int n = 0; n < 40; n++) begin
            run_event("rand", trig_list[$urandom_range(7)], {$urandom_range(32'hFFFF_FFFF) & 32'hFFFF_FFFC},
                      $urandom, 1'($urandom_range(1)), $urandom, int'($urandom_range(4)));
            if ($urandom_range(3) == 0) idle_cycle("rand_idle");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Sequences precise exception and `eret` handling for the five-stage MIPS pipeline. Takes the prioritised exception type latched into the MEM stage and waits for any outstanding memory-bus transaction to drain. It then issues a single commit cycle that writes CP0 (EPC, Cause.ExcCode, Cause.BD, BadVAddr, Status.EXL), flushes all stages and redirects fetch. It sits between the exception decoder's MEM-stage pipeline register and the hazard unit, CP0 and PC mux.

## Interface
- `EXC_VECTOR`, 32'hBFC0_0380, fetch target for every exception other than `eret`
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `exceptionTypeM`  in  32  prioritised type: 1 Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, A RI, C Ov, E eret, FFFF_FFFF none
- `pcM`  in  32  PC of the MEM-stage instruction
- `badAddrM`  in  32  faulting address for AdEL/AdES
- `isInDelaySlotM`  in  1  MEM instruction is in a branch delay slot
- `epcIn`  in  32  current CP0 EPC (eret target)
- `memBusy`  in  1  instruction or data bus transaction outstanding
- `stallReq`  out  1  freeze all stages
- `flushAll`  out  1  flush IF/ID/EX/MEM/WB registers
- `newPcValid`  out  1  PC mux takes `newPc`
- `newPc`  out  32  redirect target
- `cp0ExcWe`  out  1  write EPC, Cause.ExcCode and Cause.BD; set Status.EXL
- `cp0ExcCode`  out  5  Cause.ExcCode value
- `cp0Epc`  out  32  EPC value
- `cp0Bd`  out  1  Cause.BD value
- `cp0BadVAddrWe`  out  1  write BadVAddr
- `cp0BadVAddr`  out  32  BadVAddr value
- `cp0ExlClr`  out  1  clear Status.EXL (eret)
- `busy`  out  1  state ≠ IDLE

## Operation
- Trigger: `exceptionTypeM` is one of the eight listed codes. Every other value, including FFFF_FFFF, is no event.
- States: IDLE, DRAIN, COMMIT.
- IDLE with trigger:
  - Capture type, `pcM`, `badAddrM`, `isInDelaySlotM` and `epcIn`.
  - Next state is DRAIN if `memBusy`=1, otherwise COMMIT.
- DRAIN: hold until `memBusy`=0, then go to COMMIT. No timeout.
- COMMIT: one cycle, then IDLE.
- `stallReq` = (IDLE & trigger) | DRAIN. It is 0 in COMMIT.
- In COMMIT, `flushAll`=1 and `newPcValid`=1.
- Exception commit (types other than E):
  - `cp0ExcWe`=1.
  - `cp0ExcCode`: Int→0, AdEL→4, AdES→5, Sys→8, Bp→9, RI→10, Ov→12.
  - `newPc`=`EXC_VECTOR`.
  - `cp0BadVAddrWe`=1 only for AdEL/AdES, with `cp0BadVAddr`=captured bad address.
- Eret commit (type E):
  - `cp0ExlClr`=1, `newPc`=captured `epcIn`.
  - `cp0ExcWe`=0, `cp0BadVAddrWe`=0.
- All CP0 and redirect outputs are 0 outside COMMIT.
- Captured values are held unchanged through DRAIN. New triggers are ignored in DRAIN and COMMIT.

## Timing
- Reset: state IDLE; every output 0; capture registers 0.
- `rst` mid-DRAIN or in COMMIT: next cycle is IDLE with no CP0 write, flush or redirect.
- Latency from trigger to COMMIT: 1 cycle if `memBusy`=0 at the trigger cycle, otherwise 1 + N, where N is the number of cycles `memBusy` stays high.
- `memBusy` dropping in DRAIN cycle k gives COMMIT in cycle k+1.
- A trigger arriving in the COMMIT cycle is not captured. The flush removes its instruction.
- Back-to-back events: the earliest trigger after a return to IDLE is accepted.

## Configuration
- `EXC_BD_EN` defined:
  - Captured delay-slot flag = 1 → `cp0Epc`=`pcM`−4 (mod 2^32), `cp0Bd`=1.
  - Flag = 0 → `cp0Epc`=`pcM`, `cp0Bd`=0.
- `EXC_BD_EN` undefined:
  - `cp0Epc`=`pcM`, `cp0Bd`=0 always.
  - `isInDelaySlotM` is ignored and not registered.

## Structure
- `exc_pkg` holds:
  - the type constants (TYPE_INT…TYPE_ERET, TYPE_NONE);
  - the ExcCode constants;
  - the default `EXC_VECTOR`;
  - the state enum.
- One combinational sub-module, `exc_code_map`: type → {valid, isEret, excCode, badVAddrWe}. It is instantiated on the captured type.

## Test plan
- Sys (8) at `pcM`=0x8000_0010, `memBusy`=0: `stallReq` in cycle 0. Cycle 1: `cp0ExcWe`=1, `cp0ExcCode`=8, `cp0Epc`=0x8000_0010, `newPc`=0xBFC0_0380, `flushAll`=1.
- AdEL (4) with `badAddrM`=0x1234_5679 and `memBusy` high for 3 cycles: DRAIN for 3 cycles, then COMMIT with `cp0BadVAddrWe`=1, `cp0BadVAddr`=0x1234_5679, `cp0ExcCode`=4.
- Eret (E) with `epcIn`=0xBFC0_0100: COMMIT has `cp0ExlClr`=1, `newPc`=0xBFC0_0100, `cp0ExcWe`=0.
- Ov (C) at `pcM`=0x8000_0024 with `isInDelaySlotM`=1. With `EXC_BD_EN`: `cp0Epc`=0x8000_0020, `cp0Bd`=1. Without it: `cp0Epc`=0x8000_0024, `cp0Bd`=0.
- `rst` asserted in the second DRAIN cycle: all outputs 0 the next cycle, and no COMMIT ever occurs for that event.
- `exceptionTypeM`=0x0000_0003 (undefined) or FFFF_FFFF: no stall, state stays IDLE.
